// File: rtl/defect_serializer_if.sv
// Write-port bundle between the defect serializer and the
// shift-register memory stage.
interface defect_serializer_if #(
    parameter int DATA_BW = 8
);
    logic               valid_dout;
    logic [DATA_BW-1:0] dout;
    logic               is_lastdout;
    logic               wrfull;
    logic               wrend;

    modport master (
        output valid_dout,
        output dout,
        output is_lastdout,
        input  wrfull,
        input  wrend
    );

    modport slave (
        input  valid_dout,
        input  dout,
        input  is_lastdout,
        output wrfull,
        output wrend
    );
endinterface

// File: rtl/defect_serializer.sv
// Turns a syndrome bitmap into ascending defect indices, one per cycle,
// on the memory write port, honouring wrfull and waiting for wrend.
module defect_serializer #(
    parameter int NUM_SYN = 16,
    parameter int DATA_BW = 8,
    parameter int CNT_BW  = $clog2(NUM_SYN) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                syn_valid,
    input  logic [NUM_SYN-1:0]  syn_data,
    output logic                syn_ready,
    defect_serializer_if.master mem,
    output logic [CNT_BW-1:0]   defect_cnt,
    output logic                busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EMIT,
        S_NULL,
        S_WAIT_END
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [NUM_SYN-1:0] mask;
    logic [NUM_SYN-1:0] mask_n;
    logic [CNT_BW-1:0]  cnt_n;
    logic [DATA_BW-1:0] low_idx;
    logic [NUM_SYN-1:0] mask_drop_low;
    logic               one_hot;
    logic               word_valid;
    logic [DATA_BW-1:0] word_data;
    logic               word_last;

    // Scanning down leaves the lowest set index as the final assignment.
    always_comb begin
        low_idx = '0;
        for (int i = NUM_SYN - 1; i >= 0; i--) begin
            if (mask[i]) begin
                low_idx = DATA_BW'(i);
            end
        end
    end

    assign mask_drop_low = mask & (mask - NUM_SYN'(1));
    assign one_hot       = (mask != '0) && (mask_drop_low == '0);

    always_comb begin
        state_n    = state;
        mask_n     = mask;
        cnt_n      = defect_cnt;
        word_valid = 1'b0;
        word_data  = '0;
        word_last  = 1'b0;
        syn_ready  = 1'b0;

        unique case (state)
            S_IDLE: begin
                syn_ready = 1'b1;
                if (syn_valid) begin
                    mask_n  = syn_data;
                    cnt_n   = '0;
                    state_n = (syn_data != '0) ? S_EMIT : S_NULL;
                end
            end
            S_EMIT: begin
                word_valid = ~mem.wrfull;
                if (word_valid) begin
                    word_data = low_idx;
                    word_last = one_hot;
                    mask_n    = mask_drop_low;
                    cnt_n     = defect_cnt + CNT_BW'(1);
                    if (one_hot) begin
                        state_n = S_WAIT_END;
                    end
                end
            end
            S_NULL: begin
                word_valid = ~mem.wrfull;
                if (word_valid) begin
                    word_data = '1;
                    word_last = 1'b1;
                    state_n   = S_WAIT_END;
                end
            end
            S_WAIT_END: begin
                if (mem.wrend) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            mask       <= '0;
            defect_cnt <= '0;
        end else begin
            state      <= state_n;
            mask       <= mask_n;
            defect_cnt <= cnt_n;
        end
    end

    assign mem.valid_dout  = word_valid;
    assign mem.dout        = word_data;
    assign mem.is_lastdout = word_last;
    assign busy            = (state != S_IDLE);

endmodule

// File: tb/tb_defect_serializer.sv
// Directed bench for defect_serializer: hand-computed expectations,
// checked 1 time unit after each rising edge.
module tb_defect_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        syn_valid = 1'b0;
    logic [15:0] syn_data = '0;
    logic        syn_ready;
    logic [4:0]  defect_cnt;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    defect_serializer_if #(.DATA_BW(8)) mem ();

    defect_serializer #(
        .NUM_SYN(16),
        .DATA_BW(8),
        .CNT_BW (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .syn_valid (syn_valid),
        .syn_data  (syn_data),
        .syn_ready (syn_ready),
        .mem       (mem),
        .defect_cnt(defect_cnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic v, input logic [7:0] d, input logic l);
        chk({tag, ".valid"}, 32'(mem.valid_dout), 32'(v));
        chk({tag, ".dout"}, 32'(mem.dout), 32'(d));
        chk({tag, ".last"}, 32'(mem.is_lastdout), 32'(l));
    endtask

    task automatic wrend_pulse();
        mem.wrend = 1'b1;
        tick();
        mem.wrend = 1'b0;
    endtask

    task automatic offer(input logic [15:0] d);
        syn_valid = 1'b1;
        syn_data  = d;
        tick();
        syn_valid = 1'b0;
    endtask

    initial begin
        mem.wrfull = 1'b0;
        mem.wrend  = 1'b0;
        #12;
        chk_word("rst", 1'b0, 8'h00, 1'b0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.ready", 32'(syn_ready), 32'd1);
        chk("rst.cnt", 32'(defect_cnt), 32'd0);
        rst = 1'b1;
        tick();

        // 16'h8421: indices 0,5,10,15
        offer(16'h8421);
        chk_word("r1.w0", 1'b1, 8'd0, 1'b0);
        chk("r1.ready", 32'(syn_ready), 32'd0);
        chk("r1.busy", 32'(busy), 32'd1);
        tick();
        chk_word("r1.w1", 1'b1, 8'd5, 1'b0);
        tick();
        chk_word("r1.w2", 1'b1, 8'd10, 1'b0);
        tick();
        chk_word("r1.w3", 1'b1, 8'd15, 1'b1);
        tick();
        chk_word("r1.wait", 1'b0, 8'd0, 1'b0);
        chk("r1.cnt", 32'(defect_cnt), 32'd4);
        chk("r1.ready_wait", 32'(syn_ready), 32'd0);
        tick();
        chk("r1.ready_wait2", 32'(syn_ready), 32'd0);
        wrend_pulse();
        chk("r1.ready_idle", 32'(syn_ready), 32'd1);
        chk("r1.cnt_hold", 32'(defect_cnt), 32'd4);

        // empty round -> marker
        offer(16'h0000);
        chk_word("r2.mark", 1'b1, 8'hFF, 1'b1);
        chk("r2.cnt", 32'(defect_cnt), 32'd0);
        tick();
        chk_word("r2.wait", 1'b0, 8'd0, 1'b0);
        chk("r2.cnt_after", 32'(defect_cnt), 32'd0);
        chk("r2.busy", 32'(busy), 32'd1);
        wrend_pulse();

        // 16'h0003 with a 3-cycle stall after word 0
        offer(16'h0003);
        chk_word("r3.w0", 1'b1, 8'd0, 1'b0);
        tick();
        mem.wrfull = 1'b1;
        #1;
        chk_word("r3.stall0", 1'b0, 8'd0, 1'b0);
        tick();
        chk_word("r3.stall1", 1'b0, 8'd0, 1'b0);
        tick();
        chk_word("r3.stall2", 1'b0, 8'd0, 1'b0);
        tick();
        mem.wrfull = 1'b0;
        #1;
        chk_word("r3.w1", 1'b1, 8'd1, 1'b1);
        chk("r3.cnt_mid", 32'(defect_cnt), 32'd1);
        tick();
        chk_word("r3.wait", 1'b0, 8'd0, 1'b0);
        chk("r3.cnt", 32'(defect_cnt), 32'd2);
        wrend_pulse();

        // 16'h00F0 held while a 16'h0001 round is in flight
        offer(16'h0001);
        syn_valid = 1'b1;
        syn_data  = 16'h00F0;
        #1;
        chk_word("r4.w0", 1'b1, 8'd0, 1'b1);
        chk("r4.ready_emit", 32'(syn_ready), 32'd0);
        tick();
        chk("r4.ready_wait", 32'(syn_ready), 32'd0);
        chk_word("r4.wait", 1'b0, 8'd0, 1'b0);
        tick();
        chk("r4.ready_wait2", 32'(syn_ready), 32'd0);
        wrend_pulse();
        chk("r4.ready_idle", 32'(syn_ready), 32'd1);
        tick();
        syn_valid = 1'b0;
        chk_word("r4.w4", 1'b1, 8'd4, 1'b0);
        tick();
        chk_word("r4.w5", 1'b1, 8'd5, 1'b0);
        tick();
        chk_word("r4.w6", 1'b1, 8'd6, 1'b0);
        tick();
        chk_word("r4.w7", 1'b1, 8'd7, 1'b1);
        tick();
        chk("r4.cnt", 32'(defect_cnt), 32'd4);
        wrend_pulse();

        // reset mid-round after 5 words
        offer(16'hFFFF);
        for (int i = 0; i < 5; i++) begin
            chk_word($sformatf("r5.w%0d", i), 1'b1, 8'(i), 1'b0);
            tick();
        end
        rst = 1'b0;
        #1;
        chk_word("r5.rst", 1'b0, 8'd0, 1'b0);
        chk("r5.busy", 32'(busy), 32'd0);
        chk("r5.cnt", 32'(defect_cnt), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("r5.ready", 32'(syn_ready), 32'd1);
        tick();
        chk_word("r5.idle", 1'b0, 8'd0, 1'b0);
        offer(16'h0004);
        chk_word("r5.new", 1'b1, 8'd2, 1'b1);
        tick();
        chk("r5.new_cnt", 32'(defect_cnt), 32'd1);
        wrend_pulse();

        // full mask
        offer(16'hFFFF);
        for (int i = 0; i < 16; i++) begin
            chk_word($sformatf("r6.w%0d", i), 1'b1, 8'(i), 1'(i == 15));
            chk($sformatf("r6.cnt%0d", i), 32'(defect_cnt), 32'(i));
            tick();
        end
        chk_word("r6.wait", 1'b0, 8'd0, 1'b0);
        chk("r6.cnt", 32'(defect_cnt), 32'd16);
        wrend_pulse();
        chk("r6.ready", 32'(syn_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/defect_serializer.md
# defect_serializer

Front-end feeder for the single shift-register memory stage. It accepts one syndrome round at a time as a flat bitmap of NUM_SYN check outcomes. It emits the index of every set bit, lowest first, one word per cycle, on the memory's write port (valid_din/din/is_lastdin). It obeys the memory's wrfull back-pressure and does not accept the next round until the memory reports that its write phase has ended.

## Interface
Parameters:
- NUM_SYN, 16: syndrome bits per round. NUM_SYN-1 must be less than 2^DATA_BW-1.
- DATA_BW, 8: width of each emitted word. Must match the memory's DATA_BW.
- CNT_BW, `log2(NUM_SYN)+1: width of defect_cnt.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- syn_valid  in  1  a syndrome round is offered.
- syn_data  in  NUM_SYN  syndrome bitmap; bit i set means defect at index i.
- syn_ready  out  1  block can accept a round. A round transfers when syn_valid & syn_ready at posedge.
- valid_dout  out  1  to memory valid_din.
- dout  out  DATA_BW  to memory din; defect index, zero-extended.
- is_lastdout  out  1  to memory is_lastdin; marks the final word of the round.
- wrfull  in  1  from memory; while high, no word is emitted.
- wrend  in  1  from memory; the write/filling phase is complete.
- defect_cnt  out  CNT_BW  defects emitted in the current round.
- busy  out  1  state is not IDLE.

## Operation
- State machine states:
  - IDLE: syn_ready=1. On transfer, latch syn_data into mask and clear defect_cnt. Go to EMIT if mask≠0, else go to NULL.
  - EMIT:
    - valid_dout = ~wrfull.
    - dout = index of the lowest set bit of mask.
    - is_lastdout = valid_dout & (mask has exactly one bit set).
    - On each posedge with valid_dout=1: clear that bit and increment defect_cnt.
    - If the cleared bit was the last set bit, go to WAIT_END.
  - NULL: for an empty round, emit one marker word dout = {DATA_BW{1'b1}} with is_lastdout=1, gated by ~wrfull. The marker does not increment defect_cnt. Then go to WAIT_END.
  - WAIT_END: no output. When wrend=1 at posedge, go to IDLE. wrend is ignored in all other states.
- syn_ready=0 in EMIT, NULL and WAIT_END. syn_valid is ignored there, and the offered data is not latched.
- dout=0 and is_lastdout=0 whenever valid_dout=0.
- No word is ever duplicated or dropped across wrfull stalls. Emission order is strictly ascending index.
- defect_cnt holds its final value until the next transfer.

## Timing
- Reset (rst=0, asynchronous):
  - state=IDLE, mask=0, defect_cnt=0.
  - Outputs: valid_dout=0, dout=0, is_lastdout=0, busy=0, syn_ready=1.
  - Reset mid-round aborts the round with no further words emitted.
- Latency: a round accepted at edge N makes its first word visible in the cycle after edge N, assuming wrfull=0.
- Throughput: one word per cycle while wrfull=0. A round with k defects occupies k cycles in EMIT, plus the WAIT_END time.
- Outputs are combinational from registered state/mask and the live wrfull. wrfull rising in a cycle suppresses that cycle's word immediately.
- A round can be accepted no earlier than the cycle after wrend is sampled.
- mask all ones (NUM_SYN words): defect_cnt reaches NUM_SYN without overflow.

## Test plan
- syn_data=16'h8421, wrfull=0:
  - dout 0,5,10,15 on 4 consecutive cycles; is_lastdout only with 15.
  - defect_cnt=4; syn_ready=0 until the edge after a wrend pulse.
- syn_data=16'h0000: exactly one word dout=8'hFF with is_lastdout=1; defect_cnt=0; then WAIT_END.
- syn_data=16'h0003, wrfull=1 for 3 cycles after word 0:
  - valid_dout=0 during the stall.
  - Word 1 (is_lastdout=1) appears in the first cycle wrfull=0; no duplicate of word 0.
- syn_valid held with syn_data=16'h00F0 while a 16'h0001 round is in EMIT/WAIT_END:
  - Not accepted.
  - Accepted on the first IDLE cycle after wrend; dout 4,5,6,7 follow.
- syn_data=16'hFFFF, rst asserted after 5 words: outputs go 0 at once; after release syn_ready=1. A new round 16'h0004 emits dout=2 with is_lastdout=1.
- syn_data=16'hFFFF, wrfull=0: 16 words, dout 0..15; defect_cnt=16 (5-bit); is_lastdout only on 15.
